// File: rtl/pixel_collect3.sv
// pixel_collect3
// Gathers one colour result from each of three render engines into three
// slots. Once all three slots are full, the slots are streamed out as three
// ready/valid beats in slot order, with frame and line markers taken from a
// raster pixel counter. A one-cycle fin_flag tells the coordinate distributor
// that the batch has drained. A done strobe that finds its slot already full
// is dropped and latches the sticky overflow flag.
module pixel_collect3 #(
  parameter int COLOR_WIDTH   = 24,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_ENGINES   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done1,
  input  logic                   done2,
  input  logic                   done3,
  input  logic [COLOR_WIDTH-1:0] color1,
  input  logic [COLOR_WIDTH-1:0] color2,
  input  logic [COLOR_WIDTH-1:0] color3,
  output logic [COLOR_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   fin_flag,
  output logic                   overflow
);

  localparam int PX_W = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
  localparam int PY_W = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;

  localparam logic [1:0]      LAST_BEAT = 2'(NUM_ENGINES - 1);
  localparam logic [PX_W-1:0] PX_MAX    = PX_W'(SCREEN_WIDTH - 1);
  localparam logic [PY_W-1:0] PY_MAX    = PY_W'(SCREEN_HEIGHT - 1);
  localparam logic [PX_W-1:0] PX_ZERO   = PX_W'(0);
  localparam logic [PY_W-1:0] PY_ZERO   = PY_W'(0);
  localparam logic [PX_W-1:0] PX_ONE    = PX_W'(1);
  localparam logic [PY_W-1:0] PY_ONE    = PY_W'(1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  // registered state
  state_t                 state_r;
  logic [COLOR_WIDTH-1:0] slot_data_r [3];
  logic [2:0]             slot_full_r;
  logic [1:0]             beat_r;
  logic [PX_W-1:0]        px_r;
  logic [PY_W-1:0]        py_r;
  logic [COLOR_WIDTH-1:0] out_data_r;
  logic                   out_valid_r;
  logic                   out_sof_r;
  logic                   out_eol_r;
  logic                   fin_flag_r;
  logic                   overflow_r;

  // next-state values
  state_t                 state_s;
  logic [COLOR_WIDTH-1:0] slot_data_s [3];
  logic [2:0]             slot_full_s;
  logic [1:0]             beat_s;
  logic [PX_W-1:0]        px_s;
  logic [PY_W-1:0]        py_s;
  logic [COLOR_WIDTH-1:0] out_data_s;
  logic                   out_valid_s;
  logic                   out_sof_s;
  logic                   out_eol_s;
  logic                   fin_flag_s;
  logic                   overflow_s;

  // decoded events
  logic [2:0]             done_s;
  logic [COLOR_WIDTH-1:0] color_s [3];
  logic [2:0]             capture_s;
  logic                   accept_s;
  logic                   last_accept_s;

  assign done_s     = {done3, done2, done1};
  assign color_s[0] = color1;
  assign color_s[1] = color2;
  assign color_s[2] = color3;

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_sof   = out_sof_r;
  assign out_eol   = out_eol_r;
  assign fin_flag  = fin_flag_r;
  assign overflow  = overflow_r;

  // Handshake decode: a beat moves only when it is both offered and taken.
  always_comb begin
    accept_s      = out_valid_r && out_ready;
    last_accept_s = 1'b0;
    if (accept_s && (beat_r == LAST_BEAT)) begin
      last_accept_s = 1'b1;
    end else begin
      last_accept_s = 1'b0;
    end
  end

  // Slot capture: a strobe is taken only into an empty slot and never on the
  // edge that drains the batch; anything else is dropped and flagged.
  always_comb begin
    capture_s  = 3'b000;
    overflow_s = overflow_r;
    for (int i = 0; i < 3; i++) begin
      if (done_s[i] && (slot_full_r[i] || last_accept_s)) begin
        capture_s[i] = 1'b0;
        overflow_s   = 1'b1;
      end else if (done_s[i]) begin
        capture_s[i] = 1'b1;
      end else begin
        capture_s[i] = 1'b0;
      end
    end
  end

  // Slot contents and full bits for the next cycle.
  always_comb begin
    slot_data_s = slot_data_r;
    slot_full_s = slot_full_r;
    for (int i = 0; i < 3; i++) begin
      if (capture_s[i]) begin
        slot_data_s[i] = color_s[i];
      end else begin
        slot_data_s[i] = slot_data_r[i];
      end
    end
    if (last_accept_s) begin
      slot_full_s = 3'b000;
    end else begin
      slot_full_s = slot_full_r | capture_s;
    end
  end

  // Beat index and raster counter: both step only on an accepted beat. The
  // raster counter runs continuously across batches, so a line may end in
  // the middle of a batch.
  always_comb begin
    beat_s = beat_r;
    px_s   = px_r;
    py_s   = py_r;
    if (accept_s) begin
      if (last_accept_s) begin
        beat_s = 2'd0;
      end else begin
        beat_s = beat_r + 2'd1;
      end
      if (px_r == PX_MAX) begin
        px_s = PX_ZERO;
        if (py_r == PY_MAX) begin
          py_s = PY_ZERO;
        end else begin
          py_s = py_r + PY_ONE;
        end
      end else begin
        px_s = px_r + PX_ONE;
        py_s = py_r;
      end
    end else begin
      beat_s = beat_r;
      px_s   = px_r;
      py_s   = py_r;
    end
  end

  // Collect/emit sequencing: enter EMIT on the edge the last slot fills,
  // leave it on acceptance of the final beat.
  always_comb begin
    state_s    = state_r;
    fin_flag_s = last_accept_s;
    case (state_r)
      COLLECT: begin
        if (&slot_full_s) begin
          state_s = EMIT;
        end else begin
          state_s = COLLECT;
        end
      end
      EMIT: begin
        if (last_accept_s) begin
          state_s = COLLECT;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = COLLECT;
      end
    endcase
  end

  // Output beat for the next cycle, computed from next-state values so the
  // first beat is presented right after the edge that completed the batch.
  // While stalled none of the inputs to this block change, so the beat holds.
  always_comb begin
    out_valid_s = (state_s == EMIT);
    out_data_s  = {COLOR_WIDTH{1'b0}};
    out_sof_s   = 1'b0;
    out_eol_s   = 1'b0;
    if (out_valid_s) begin
      case (beat_s)
        2'd0:    out_data_s = slot_data_s[0];
        2'd1:    out_data_s = slot_data_s[1];
        2'd2:    out_data_s = slot_data_s[2];
        default: out_data_s = {COLOR_WIDTH{1'b0}};
      endcase
      out_sof_s = (px_s == PX_ZERO) && (py_s == PY_ZERO);
      out_eol_s = (px_s == PX_MAX);
    end else begin
      out_data_s = {COLOR_WIDTH{1'b0}};
      out_sof_s  = 1'b0;
      out_eol_s  = 1'b0;
    end
  end

  // State and output registers; reset overrides every same-cycle event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= COLLECT;
      for (int i = 0; i < 3; i++) begin
        slot_data_r[i] <= {COLOR_WIDTH{1'b0}};
      end
      slot_full_r <= 3'b000;
      beat_r      <= 2'd0;
      px_r        <= PX_ZERO;
      py_r        <= PY_ZERO;
      out_data_r  <= {COLOR_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      out_eol_r   <= 1'b0;
      fin_flag_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      for (int i = 0; i < 3; i++) begin
        slot_data_r[i] <= slot_data_s[i];
      end
      slot_full_r <= slot_full_s;
      beat_r      <= beat_s;
      px_r        <= px_s;
      py_r        <= py_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      out_sof_r   <= out_sof_s;
      out_eol_r   <= out_eol_s;
      fin_flag_r  <= fin_flag_s;
      overflow_r  <= overflow_s;
    end
  end

endmodule
